// File: rtl/router_out_arb.sv
// router_out_arb: packet-granular round-robin drain of three output FIFOs
// onto one byte channel, with header length parsing and stall timeout.
module router_out_arb #(
  parameter int TIMEOUT = 30,
  parameter int NPORT   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  input  logic       out_ready,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_port,
  output logic       arb_busy,
  output logic       hdr_err,
  output logic       timeout_err
);

  localparam int         SW   = $clog2(TIMEOUT + 1);
  localparam logic [1:0] LAST = 2'(NPORT - 1);

  typedef enum logic [1:0] {IDLE, HDR, HWAIT, STREAM} state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    rr_q, rr_d;
  logic [1:0]    port_q, port_d;
  logic [6:0]    rem_q, rem_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          tmo_q, tmo_d;

  logic [2:0] empty_v;
  logic [2:0] sr_v;
  logic       emp_g;
  logic       sr_g;
  logic [7:0] gdata;
  logic [7:0] pdata;
  logic [1:0] pick;
  logic       issue;

  function automatic logic bit_of(input logic [2:0] v,
                                  input logic [1:0] i);
    logic b;
    case (i)
      2'd0:    b = v[0];
      2'd1:    b = v[1];
      2'd2:    b = v[2];
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  function automatic logic [1:0] inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign empty_v = {empty_2, empty_1, empty_0};
  assign sr_v    = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign emp_g   = bit_of(empty_v, grant_q);
  assign sr_g    = bit_of(~sr_v, grant_q) == 1'b0;

  always_comb begin
    gdata = 8'h00;
    case (grant_q)
      2'd0:    gdata = data_out_0;
      2'd1:    gdata = data_out_1;
      2'd2:    gdata = data_out_2;
      default: gdata = 8'h00;
    endcase
  end

  always_comb begin
    pdata = 8'h00;
    case (port_q)
      2'd0:    pdata = data_out_0;
      2'd1:    pdata = data_out_1;
      2'd2:    pdata = data_out_2;
      default: pdata = 8'h00;
    endcase
  end

  always_comb begin
    pick = inc(inc(rr_q));
    if (!bit_of(empty_v, rr_q))
      pick = rr_q;
    else if (!bit_of(empty_v, inc(rr_q)))
      pick = inc(rr_q);
  end

  // Reads are withheld during reset so the FIFOs keep their contents.
  assign issue = out_ready & ~emp_g & ~sr_g & ~reset &
                 ((state_q == HDR) |
                  ((state_q == STREAM) & (rem_q != 7'd0)));

  assign read_enb_0 = issue & (grant_q == 2'd0);
  assign read_enb_1 = issue & (grant_q == 2'd1);
  assign read_enb_2 = issue & (grant_q == 2'd2);

  assign hdr_err = (state_q == HWAIT) & ~sr_g &
                   (gdata[1:0] != grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    stall_d = stall_q;
    tmo_d   = 1'b0;
    valid_d = issue;
    sop_d   = issue & (state_q == HDR);
    eop_d   = issue & (state_q == STREAM) & (rem_q == 7'd1);
    port_d  = issue ? grant_q : port_q;
    unique case (state_q)
      IDLE: begin
        stall_d = '0;
        if (!(&empty_v)) begin
          grant_d = pick;
          state_d = HDR;
        end
      end
      HDR: begin
        if (sr_g) begin
          state_d = IDLE;
          rr_d    = inc(grant_q);
        end else if (issue) begin
          state_d = HWAIT;
        end
      end
      HWAIT: begin
        if (sr_g) begin
          state_d = IDLE;
          rr_d    = inc(grant_q);
        end else begin
          rem_d   = {1'b0, gdata[7:2]} + 7'd1;
          stall_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (sr_g) begin
          state_d = IDLE;
          rr_d    = inc(grant_q);
          stall_d = '0;
        end else if (issue) begin
          rem_d   = rem_q - 7'd1;
          stall_d = '0;
          if (rem_q == 7'd1) begin
            state_d = IDLE;
            rr_d    = inc(grant_q);
          end
        end else if (emp_g && rem_q != 7'd0) begin
          if (stall_q == SW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            rr_d    = inc(grant_q);
            stall_d = '0;
            tmo_d   = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      rr_q    <= 2'd0;
      port_q  <= 2'd0;
      rem_q   <= 7'd0;
      stall_q <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      port_q  <= port_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      tmo_q   <= tmo_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_sop     = sop_q;
  assign out_eop     = eop_q;
  assign out_port    = port_q;
  assign timeout_err = tmo_q;
  assign arb_busy    = (state_q != IDLE);
  assign out_data    = valid_q ? pdata : 8'h00;

endmodule

// File: tb/tb_router_out_arb.sv
// tb_router_out_arb: directed vectors against queue-modelled FIFOs,
// hand-computed byte streams, grant order, errors and reset behaviour.
module tb_router_out_arb;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       empty_0 = 1'b1;
  logic       empty_1 = 1'b1;
  logic       empty_2 = 1'b1;
  logic       soft_reset_0 = 1'b0;
  logic       soft_reset_1 = 1'b0;
  logic       soft_reset_2 = 1'b0;
  logic [7:0] data_out_0 = 8'h00;
  logic [7:0] data_out_1 = 8'h00;
  logic [7:0] data_out_2 = 8'h00;
  logic       out_ready = 1'b1;
  logic       read_enb_0;
  logic       read_enb_1;
  logic       read_enb_2;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic [1:0] out_port;
  logic       arb_busy;
  logic       hdr_err;
  logic       timeout_err;

  router_out_arb #(.TIMEOUT(30), .NPORT(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .empty_0      (empty_0),
    .empty_1      (empty_1),
    .empty_2      (empty_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .data_out_0   (data_out_0),
    .data_out_1   (data_out_1),
    .data_out_2   (data_out_2),
    .out_ready    (out_ready),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_port     (out_port),
    .arb_busy     (arb_busy),
    .hdr_err      (hdr_err),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] port;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } ev_t;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  ev_t        evl[$];
  logic [1:0] sops[$];

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int nre0 = 0;
  int nre1 = 0;
  int nre2 = 0;
  int nhdr = 0;
  int ntmo = 0;
  int neop = 0;
  int tmo_cyc = 0;
  int val_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO models: one-cycle read latency, soft reset clears contents.
  always @(posedge clock) begin
    if (soft_reset_0) q0.delete();
    else if (read_enb_0 && q0.size() > 0) data_out_0 <= q0.pop_front();
    if (soft_reset_1) q1.delete();
    else if (read_enb_1 && q1.size() > 0) data_out_1 <= q1.pop_front();
    if (soft_reset_2) q2.delete();
    else if (read_enb_2 && q2.size() > 0) data_out_2 <= q2.pop_front();
    empty_0 <= (q0.size() == 0);
    empty_1 <= (q1.size() == 0);
    empty_2 <= (q2.size() == 0);
  end

  always @(negedge clock) begin
    cyc++;
    if (out_valid) begin
      evl.push_back({out_port, out_sop, out_eop, out_data});
      val_cyc = cyc;
    end
    if (out_sop) sops.push_back(out_port);
    if (out_eop) neop++;
    if (read_enb_0) nre0++;
    if (read_enb_1) nre1++;
    if (read_enb_2) nre2++;
    if (hdr_err) nhdr++;
    if (timeout_err) begin
      ntmo++;
      tmo_cyc = cyc;
    end
    chk("one_hot",
        32'($countones({read_enb_2, read_enb_1, read_enb_0}) > 1), 0);
    chk("re_empty", 32'((read_enb_0 & empty_0) | (read_enb_1 & empty_1) |
                        (read_enb_2 & empty_2)), 0);
    chk("re_no_rdy",
        32'((read_enb_0 | read_enb_1 | read_enb_2) & ~out_ready), 0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int p, input logic [7:0] b);
    case (p)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic do_reset(input bit clr);
    reset = 1'b1;
    if (clr) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_sop(input string tag);
    int n;
    n = 0;
    while (!out_sop && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(out_sop), 1);
  endtask

  task automatic chk_ev(input string tag, input int idx,
                        input logic [1:0] port, input logic sop,
                        input logic eop, input logic [7:0] data);
    ev_t e;
    e = '0;
    if (idx < evl.size()) e = evl[idx];
    chk(tag, 32'(e), 32'({port, sop, eop, data}));
  endtask

  int b_ev, b_sop, b_re, b_hdr, b_tmo, b_eop;

  initial begin
    // 1: single packet from FIFO0, L=3
    do_reset(1);
    chk("rst_busy", 32'(arb_busy), 0);
    chk("rst_outs", 32'({read_enb_2, read_enb_1, read_enb_0, out_valid,
                         out_sop, out_eop, hdr_err, timeout_err}), 0);
    chk("rst_port", 32'(out_port), 0);
    chk("rst_data", 32'(out_data), 0);
    b_ev = evl.size();
    b_re = nre0;
    b_eop = neop;
    push(0, 8'h0C); push(0, 8'hA1); push(0, 8'hA2);
    push(0, 8'hA3); push(0, 8'h77);
    repeat (15) tick();
    chk("t1_re0", 32'(nre0 - b_re), 5);
    chk("t1_nval", 32'(evl.size() - b_ev), 5);
    chk_ev("t1_hdr", b_ev + 0, 2'd0, 1'b1, 1'b0, 8'h0C);
    chk_ev("t1_p1", b_ev + 1, 2'd0, 1'b0, 1'b0, 8'hA1);
    chk_ev("t1_p2", b_ev + 2, 2'd0, 1'b0, 1'b0, 8'hA2);
    chk_ev("t1_p3", b_ev + 3, 2'd0, 1'b0, 1'b0, 8'hA3);
    chk_ev("t1_par", b_ev + 4, 2'd0, 1'b0, 1'b1, 8'h77);
    chk("t1_neop", 32'(neop - b_eop), 1);
    chk("t1_busy", 32'(arb_busy), 0);

    // 2: three L=1 packets from reset, then round-robin follow-ups
    do_reset(1);
    b_ev = evl.size();
    for (int p = 0; p < 3; p++) begin
      push(p, 8'(4 + p));
      push(p, 8'(16 * (p + 1)));
      push(p, 8'(16 * (p + 1) + 1));
    end
    repeat (30) tick();
    chk("t2_nval", 32'(evl.size() - b_ev), 9);
    for (int p = 0; p < 3; p++) begin
      chk_ev("t2_hdr", b_ev + 3 * p, 2'(p), 1'b1, 1'b0, 8'(4 + p));
      chk_ev("t2_pay", b_ev + 3 * p + 1, 2'(p), 1'b0, 1'b0,
             8'(16 * (p + 1)));
      chk_ev("t2_par", b_ev + 3 * p + 2, 2'(p), 1'b0, 1'b1,
             8'(16 * (p + 1) + 1));
    end
    b_sop = sops.size();
    push(1, 8'h01); push(1, 8'h6A);
    push(0, 8'h00); push(0, 8'h5A);
    repeat (15) tick();
    chk("t2_rr0_a", 32'(sops.size() > b_sop ? sops[b_sop] : 2'd3), 0);
    chk("t2_rr0_b", 32'(sops.size() > b_sop + 1 ? sops[b_sop + 1] : 2'd3),
        1);
    push(0, 8'h00); push(0, 8'h5B);
    repeat (10) tick();
    b_sop = sops.size();
    push(0, 8'h00); push(0, 8'h5C);
    push(1, 8'h01); push(1, 8'h6C);
    repeat (15) tick();
    chk("t2_rr1_a", 32'(sops.size() > b_sop ? sops[b_sop] : 2'd3), 1);
    chk("t2_rr1_b", 32'(sops.size() > b_sop + 1 ? sops[b_sop + 1] : 2'd3),
        0);

    // 3: out_ready throttling with a gap longer than TIMEOUT
    do_reset(1);
    b_ev = evl.size();
    b_re = nre0;
    b_tmo = ntmo;
    push(0, 8'h08); push(0, 8'hB1); push(0, 8'hB2); push(0, 8'hB3);
    wait_sop("t3_sop");
    tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; repeat (40) tick();
    chk("t3_busy_gap", 32'(arb_busy), 1);
    out_ready = 1'b1; repeat (5) tick();
    chk("t3_nval", 32'(evl.size() - b_ev), 4);
    chk_ev("t3_hdr", b_ev + 0, 2'd0, 1'b1, 1'b0, 8'h08);
    chk_ev("t3_p1", b_ev + 1, 2'd0, 1'b0, 1'b0, 8'hB1);
    chk_ev("t3_p2", b_ev + 2, 2'd0, 1'b0, 1'b0, 8'hB2);
    chk_ev("t3_par", b_ev + 3, 2'd0, 1'b0, 1'b1, 8'hB3);
    chk("t3_re0", 32'(nre0 - b_re), 4);
    chk("t3_ntmo", 32'(ntmo - b_tmo), 0);

    // 4: header addr mismatch and starvation timeout on FIFO2
    do_reset(1);
    b_ev = evl.size();
    b_hdr = nhdr;
    b_tmo = ntmo;
    b_eop = neop;
    push(2, 8'h21); push(2, 8'hC1); push(2, 8'hC2); push(2, 8'hC3);
    wait_sop("t4_sop");
    chk("t4_hdr_now", 32'(hdr_err), 1);
    chk("t4_port", 32'(out_port), 2);
    repeat (50) tick();
    chk("t4_nhdr", 32'(nhdr - b_hdr), 1);
    chk("t4_ntmo", 32'(ntmo - b_tmo), 1);
    chk("t4_tmo_gap", 32'(tmo_cyc - val_cyc), 30);
    chk("t4_neop", 32'(neop - b_eop), 0);
    chk("t4_nval", 32'(evl.size() - b_ev), 4);
    chk_ev("t4_last", b_ev + 3, 2'd2, 1'b0, 1'b0, 8'hC3);
    chk("t4_busy", 32'(arb_busy), 0);

    // 5: soft reset of the granted port mid-stream
    do_reset(1);
    b_ev = evl.size();
    b_eop = neop;
    b_tmo = ntmo;
    b_hdr = nhdr;
    push(1, 8'h11); push(1, 8'hD1); push(1, 8'hD2);
    push(1, 8'hD3); push(1, 8'hD4); push(1, 8'hD5);
    push(2, 8'h02); push(2, 8'hE0);
    wait_sop("t5_sop");
    chk("t5_port", 32'(out_port), 1);
    tick();
    tick();
    soft_reset_1 = 1'b1;
    #1;
    chk("t5_re1", 32'(read_enb_1), 0);
    chk("t5_busy_pre", 32'(arb_busy), 1);
    tick();
    soft_reset_1 = 1'b0;
    chk("t5_busy", 32'(arb_busy), 0);
    repeat (15) tick();
    chk("t5_nval", 32'(evl.size() - b_ev), 4);
    chk_ev("t5_h1", b_ev + 0, 2'd1, 1'b1, 1'b0, 8'h11);
    chk_ev("t5_d1", b_ev + 1, 2'd1, 1'b0, 1'b0, 8'hD1);
    chk_ev("t5_h2", b_ev + 2, 2'd2, 1'b1, 1'b0, 8'h02);
    chk_ev("t5_p2", b_ev + 3, 2'd2, 1'b0, 1'b1, 8'hE0);
    chk("t5_neop", 32'(neop - b_eop), 1);
    chk("t5_errs", 32'((ntmo - b_tmo) + (nhdr - b_hdr)), 0);

    // 6: reset during an L=63 packet
    do_reset(1);
    push(0, 8'hFC);
    for (int i = 0; i < 64; i++) push(0, 8'(i + 1));
    push(2, 8'h06); push(2, 8'h30); push(2, 8'h31);
    wait_sop("t6_sop");
    chk("t6_port", 32'(out_port), 0);
    repeat (10) tick();
    chk("t6_busy_mid", 32'(arb_busy), 1);
    reset = 1'b1;
    tick();
    chk("t6_outs", 32'({read_enb_2, read_enb_1, read_enb_0, out_valid,
                        out_sop, out_eop, hdr_err, timeout_err,
                        arb_busy}), 0);
    chk("t6_data", 32'({out_port, out_data}), 0);
    reset = 1'b0;
    wait_sop("t6_sop2");
    chk("t6_port2", 32'(out_port), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
